// File: rtl/cell_plotter.sv
// Latches a cell column/row and paints that cell as a CELL_SIZE x CELL_SIZE block of VGA pixel writes in raster order.
// Latency: first write one cycle after draw is accepted, CELL_SIZE^2 back-to-back writes, then a one-cycle done pulse.
// No backpressure: draw is only taken while idle (busy low); a draw arriving while busy is dropped, not queued.
module cell_plotter #(
    parameter int CELL_SIZE = 4,
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic [2:0] colour_in,
    input  logic       ld_x,
    input  logic       ld_y,
    input  logic       draw,
    output logic       busy,
    output logic       done,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       writeEn
);

    localparam int PX_W  = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;
    localparam int COL_W = $clog2(GRID_W);
    localparam int ROW_W = $clog2(GRID_H);
    localparam logic [PX_W-1:0] PX_MAX = PX_W'(CELL_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLOT,
        S_DONE
    } state_t;

    state_t            state;
    logic [COL_W-1:0]  col_p;
    logic [ROW_W-1:0]  row_p;
    logic [COL_W-1:0]  col_a;
    logic [ROW_W-1:0]  row_a;
    logic [2:0]        colour_a;
    logic [PX_W-1:0]   px;
    logic [PX_W-1:0]   py;
    logic [PX_W-1:0]   px_nxt;
    logic [PX_W-1:0]   py_nxt;
    logic              last_pix;

    // Clamping here is what keeps the 8/7-bit pixel products from ever wrapping.
    function automatic logic [COL_W-1:0] clamp_col(input logic [7:0] d);
        if (d > 8'(GRID_W - 1))
            return COL_W'(GRID_W - 1);
        return d[COL_W-1:0];
    endfunction

    function automatic logic [ROW_W-1:0] clamp_row(input logic [7:0] d);
        if (d > 8'(GRID_H - 1))
            return ROW_W'(GRID_H - 1);
        return d[ROW_W-1:0];
    endfunction

    function automatic logic [7:0] pix_x(input logic [COL_W-1:0] c, input logic [PX_W-1:0] p);
        return 8'(c) * 8'(CELL_SIZE) + 8'(p);
    endfunction

    function automatic logic [6:0] pix_y(input logic [ROW_W-1:0] r, input logic [PX_W-1:0] p);
        return 7'(r) * 7'(CELL_SIZE) + 7'(p);
    endfunction

    always_comb begin
        px_nxt   = px + 1'b1;
        py_nxt   = py;
        last_pix = (px == PX_MAX) && (py == PX_MAX);
        if (px == PX_MAX) begin
            px_nxt = '0;
            py_nxt = py + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            col_p      <= '0;
            row_p      <= '0;
            col_a      <= '0;
            row_a      <= '0;
            colour_a   <= '0;
            px         <= '0;
            py         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            writeEn    <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
        end else begin
            // Pending coordinates load in any state; the active cell is only replaced on an accepted draw.
            if (ld_x)
                col_p <= clamp_col(data_in);
            if (ld_y)
                row_p <= clamp_row(data_in);

            case (state)
                S_IDLE: begin
                    if (draw) begin
                        state      <= S_PLOT;
                        col_a      <= col_p;
                        row_a      <= row_p;
                        colour_a   <= colour_in;
                        px         <= '0;
                        py         <= '0;
                        busy       <= 1'b1;
                        writeEn    <= 1'b1;
                        x_out      <= pix_x(col_p, '0);
                        y_out      <= pix_y(row_p, '0);
                        colour_out <= colour_in;
                    end
                end
                S_PLOT: begin
                    if (last_pix) begin
                        state   <= S_DONE;
                        writeEn <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        px         <= px_nxt;
                        py         <= py_nxt;
                        x_out      <= pix_x(col_a, px_nxt);
                        y_out      <= pix_y(row_a, py_nxt);
                        colour_out <= colour_a;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    writeEn <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cell_plotter.sv
// Bench for cell_plotter: directed cases plus random traffic checked every cycle against a timeline model.
module tb_cell_plotter;

    localparam int CS   = 4;
    localparam int GW   = 40;
    localparam int GH   = 30;
    localparam int NPIX = CS * CS;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic [2:0] colour_in;
    logic       ld_x;
    logic       ld_y;
    logic       draw;
    logic       busy;
    logic       done;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       writeEn;

    cell_plotter #(.CELL_SIZE(CS), .GRID_W(GW), .GRID_H(GH)) dut (
        .clock     (clock),
        .reset     (reset),
        .data_in   (data_in),
        .colour_in (colour_in),
        .ld_x      (ld_x),
        .ld_y      (ld_y),
        .draw      (draw),
        .busy      (busy),
        .done      (done),
        .x_out     (x_out),
        .y_out     (y_out),
        .colour_out(colour_out),
        .writeEn   (writeEn)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Model: a cell started at edge s writes during cycles s..s+15, pulses done at s+16, idles from s+17.
    int edge_no  = 0;
    int start    = -1;
    int m_col_p  = 0;
    int m_row_p  = 0;
    int a_col    = 0;
    int a_row    = 0;
    int a_colour = 0;
    int last_x   = 0;
    int last_y   = 0;
    int last_c   = 0;
    int max_x    = 0;
    int max_y    = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, edge_no, got, exp);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_edge(input bit r, input bit dr, input bit lx, input bit ly,
                              input int d, input int c);
        if (r) begin
            start   = -1;
            m_col_p = 0;
            m_row_p = 0;
            last_x  = 0;
            last_y  = 0;
            last_c  = 0;
        end else begin
            if (dr && (start < 0 || edge_no >= start + NPIX + 2)) begin
                start    = edge_no;
                a_col    = m_col_p;
                a_row    = m_row_p;
                a_colour = c;
            end
            if (lx) m_col_p = min_i(d, GW - 1);
            if (ly) m_row_p = min_i(d, GH - 1);
        end
    endtask

    task automatic compare_cycle();
        int k;
        bit exp_wen, exp_done, exp_busy;
        k        = (start < 0) ? 1000 : edge_no - start;
        exp_wen  = (k < NPIX);
        exp_done = (k == NPIX);
        exp_busy = (k <= NPIX);
        if (exp_wen) begin
            last_x = a_col * CS + (k % CS);
            last_y = a_row * CS + (k / CS);
            last_c = a_colour;
        end
        check("writeEn", int'(writeEn), int'(exp_wen));
        check("done", int'(done), int'(exp_done));
        check("busy", int'(busy), int'(exp_busy));
        check("x_out", int'(x_out), last_x);
        check("y_out", int'(y_out), last_y);
        check("colour_out", int'(colour_out), last_c);
        if (writeEn) begin
            if (int'(x_out) > max_x) max_x = int'(x_out);
            if (int'(y_out) > max_y) max_y = int'(y_out);
        end
    endtask

    task automatic step(input bit r, input bit dr, input bit lx, input bit ly,
                        input int d, input int c);
        reset     = r;
        draw      = dr;
        ld_x      = lx;
        ld_y      = ly;
        data_in   = 8'(d);
        colour_in = 3'(c);
        @(posedge clock);
        edge_no++;
        model_edge(r, dr, lx, ly, d, c);
        #1;
        compare_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; draw = 1'b0; ld_x = 1'b0; ld_y = 1'b0; data_in = '0; colour_in = '0;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        idle(2);

        // Basic cell (3,2) colour 5.
        step(0, 0, 1, 0, 3, 0);
        step(0, 0, 0, 1, 2, 0);
        step(0, 1, 0, 0, 0, 5);
        idle(20);

        // Out-of-range coordinates clamp to the last column/row.
        max_x = 0; max_y = 0;
        step(0, 0, 1, 0, 45, 0);
        step(0, 0, 0, 1, 99, 0);
        step(0, 1, 0, 0, 0, 3);
        idle(20);
        check("clamp_max_x", max_x, GW * CS - 1);
        check("clamp_max_y", max_y, GH * CS - 1);

        // Pending loads mid-plot do not disturb the active cell.
        step(0, 0, 1, 1, 1, 0);
        step(0, 1, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 2);
        step(0, 1, 1, 0, 7, 6);
        idle(16);
        step(0, 1, 0, 0, 0, 4);
        idle(20);

        // draw held high for 40 cycles.
        for (int i = 0; i < 40; i++) step(0, 1, 0, 0, 0, i % 8);
        idle(20);

        // Reset on the 5th write cycle.
        step(0, 1, 0, 0, 0, 1);
        idle(4);
        step(1, 0, 0, 0, 0, 0);
        idle(20);

        // ld_x with draw in the same cycle uses the old column.
        step(0, 0, 1, 0, 1, 0);
        step(0, 1, 1, 0, 4, 7);
        idle(18);
        step(0, 1, 0, 0, 0, 7);
        idle(20);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 45)),
                 int'($urandom_range(0, 7)));
        end
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
